// File: rtl/dbus_pkg.sv
// Shared constants and types for the data-bus responder and its console FIFO.
package dbus_pkg;

  localparam logic [31:0] DEF_MMIO_BASE = 32'h8000_0000;

  // Word offsets inside the MMIO window, compared against DataAdr[3:2]
  localparam logic [1:0] TOHOST_OFS  = 2'd0;
  localparam logic [1:0] CONSOLE_OFS = 2'd1;
  localparam logic [1:0] CYCLE_OFS   = 2'd2;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

endpackage

// File: rtl/con_fifo.sv
// Console byte FIFO: push side from the bus, valid/ready pop side to the consumer.
// A push into a full FIFO still lands when the head is popped in the same cycle.
module con_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  input  logic             ready,
  output logic             empty,
  output logic             accepted,
  output logic             dropped
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign valid    = !empty;
  assign pop      = valid && ready;
  assign accepted = push && (!full || pop);
  assign dropped  = push && !accepted;
  // Masked so the consumer sees zero rather than stale storage when empty
  assign rdata    = empty ? '0 : mem_q[rd_ptr_q[IW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accepted) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accepted) mem_q[wr_ptr_q[IW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-side bus target for the single-cycle core: byte-enabled word RAM plus an
// MMIO window holding TOHOST, the console FIFO and a free-running cycle counter.
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          MEM_WORDS  = 256,
  parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE,
  parameter int          FIFO_DEPTH = 4,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] ReadData,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_code,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        bus_err,
  output logic        con_ovf
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS) << 2;

  logic [31:0] mem_q [MEM_WORDS];

  region_e     region;
  logic [AW-1:0] ram_idx;
  logic [1:0]  mmio_ofs;
  logic        ram_we, tohost_we, con_push;

  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic        bus_err_q, bus_err_d;
  logic        con_ovf_q, con_ovf_d;
  logic [31:0] cycle_q, cycle_d;

  logic        fifo_full, fifo_empty, fifo_dropped;

  assign ram_idx  = DataAdr[AW+1:2];
  assign mmio_ofs = DataAdr[3:2];

  // RAM wins if a small MMIO_BASE ever overlaps the RAM range
  always_comb begin
    region = REG_NONE;
    if (DataAdr < RAM_BYTES)                     region = REG_RAM;
    else if (DataAdr[31:4] == MMIO_BASE[31:4])   region = REG_MMIO;
  end

  assign ram_we    = MemWrite && !reset && (region == REG_RAM);
  assign tohost_we = MemWrite && !reset && (region == REG_MMIO) &&
                     (mmio_ofs == TOHOST_OFS) && (ByteEn == 4'hF) && !done_q;
  assign con_push  = MemWrite && !reset && (region == REG_MMIO) &&
                     (mmio_ofs == CONSOLE_OFS) && ByteEn[0];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ByteEn[i]) mem_q[ram_idx][8*i +: 8] <= WriteData[8*i +: 8];
      end
    end
  end

  con_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_con_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (con_push),
    .wdata    (WriteData[7:0]),
    .full     (fifo_full),
    .valid    (con_valid),
    .rdata    (con_data),
    .ready    (con_ready),
    .empty    (fifo_empty),
    .accepted (),
    .dropped  (fifo_dropped)
  );

  always_comb begin
    ReadData = '0;
    case (region)
      REG_RAM:  ReadData = mem_q[ram_idx];
      REG_MMIO: begin
        case (mmio_ofs)
          CONSOLE_OFS: begin
            ReadData[STAT_FULL]  = fifo_full;
            ReadData[STAT_EMPTY] = fifo_empty;
          end
          CYCLE_OFS: ReadData = cycle_q;
          default:   ReadData = '0;
        endcase
      end
      default:  ReadData = '0;
    endcase
  end

  always_comb begin
    done_d      = done_q;
    pass_d      = pass_q;
    fail_code_d = fail_code_q;
    if (tohost_we) begin
      done_d      = 1'b1;
      pass_d      = (WriteData == 32'd1);
      fail_code_d = WriteData[31:1];
    end
    cycle_d   = done_q ? cycle_q : cycle_q + 32'd1;
    // Address is driven every cycle, so an unmapped address is an access
    bus_err_d = bus_err_q | (region == REG_NONE);
    con_ovf_d = con_ovf_q | fifo_dropped;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= '0;
      bus_err_q   <= 1'b0;
      con_ovf_q   <= 1'b0;
      cycle_q     <= '0;
    end else begin
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_code_q <= fail_code_d;
      bus_err_q   <= bus_err_d;
      con_ovf_q   <= con_ovf_d;
      cycle_q     <= cycle_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = fail_code_q;
  assign bus_err   = bus_err_q;
  assign con_ovf   = con_ovf_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: RAM lanes, TOHOST, console FIFO, counter,
// unmapped accesses and mid-run reset.
module tb_dbus_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [3:0]  ByteEn;
  logic [31:0] ReadData;
  logic        done;
  logic        pass;
  logic [30:0] fail_code;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        bus_err;
  logic        con_ovf;

  int n_checks = 0;
  int n_errors = 0;

  dbus_responder #(
    .MEM_WORDS  (256),
    .MMIO_BASE  (BASE),
    .FIFO_DEPTH (4),
    .INIT_FILE  ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ByteEn    (ByteEn),
    .ReadData  (ReadData),
    .done      (done),
    .pass      (pass),
    .fail_code (fail_code),
    .con_valid (con_valid),
    .con_data  (con_data),
    .con_ready (con_ready),
    .bus_err   (bus_err),
    .con_ovf   (con_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;
    ByteEn    = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    MemWrite = 1'b1; DataAdr = a; WriteData = d; ByteEn = be;
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    DataAdr = a;
    #1;
    d = ReadData;
    DataAdr = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; con_ready = 1'b0; idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(con_valid), 32'd1);
    check({tag, "_data"},  32'(con_data),  32'(exp));
    con_ready = 1'b1;
    @(negedge clk);
    con_ready = 1'b0;
  endtask

  logic [31:0] r;
  logic [7:0]  msg [5];
  logic [7:0]  abcd [4];

  initial begin
    msg  = '{8'h48, 8'h69, 8'h21, 8'h0A, 8'h58};
    abcd = '{8'h61, 8'h62, 8'h63, 8'h64};
    reset = 1'b1; con_ready = 1'b0; idle();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_done",      32'(done),      32'd0);
    check("rst_pass",      32'(pass),      32'd0);
    check("rst_fail_code", 32'(fail_code), 32'd0);
    check("rst_con_valid", 32'(con_valid), 32'd0);
    check("rst_con_data",  32'(con_data),  32'd0);
    check("rst_bus_err",   32'(bus_err),   32'd0);
    check("rst_con_ovf",   32'(con_ovf),   32'd0);

    // Counter: cycle 0 is the first cycle with reset low
    reset = 1'b0;
    rd(BASE + 32'h8, r); check("cycle0", r, 32'd0);
    repeat (5) @(negedge clk);
    rd(BASE + 32'h8, r); check("cycle5", r, 32'd5);

    // TOHOST fail written in cycle 5; counter takes that last step to 6 then freezes
    MemWrite = 1'b1; DataAdr = BASE; WriteData = 32'h0000_002B; ByteEn = 4'hF;
    @(negedge clk);
    idle();
    check("th_done",      32'(done),      32'd1);
    check("th_pass",      32'(pass),      32'd0);
    check("th_fail_code", 32'(fail_code), 32'd21);
    rd(BASE + 32'h8, r); check("cycle_frozen_a", r, 32'd6);
    repeat (3) @(negedge clk);
    rd(BASE + 32'h8, r); check("cycle_frozen_b", r, 32'd6);

    wr(BASE, 32'd1, 4'hF);
    check("th_sticky_done", 32'(done),      32'd1);
    check("th_sticky_pass", 32'(pass),      32'd0);
    check("th_sticky_code", 32'(fail_code), 32'd21);

    // Partial-width TOHOST write is ignored, full-width 1 passes
    do_reset();
    wr(BASE, 32'd1, 4'h7);
    check("th_partial_done", 32'(done), 32'd0);
    wr(BASE, 32'd1, 4'hF);
    check("th_pass_done", 32'(done), 32'd1);
    check("th_pass_pass", 32'(pass), 32'd1);
    check("th_pass_code", 32'(fail_code), 32'd0);
    rd(BASE, r); check("th_read_zero", r, 32'd0);

    // RAM lanes
    wr(32'h0000_0000, 32'h0BAD_F00D, 4'hF);
    wr(32'h0000_0010, 32'hAABB_CCDD, 4'hF);
    wr(32'h0000_0010, 32'h0000_EE00, 4'b0010);
    rd(32'h0000_0010, r); check("ram_lane", r, 32'hAABB_EEDD);
    wr(32'h0000_0010, 32'hFFFF_FFFF, 4'h0);
    rd(32'h0000_0010, r); check("ram_be0_noop", r, 32'hAABB_EEDD);
    wr(32'h0000_03FC, 32'h1357_9BDF, 4'b1001);
    rd(32'h0000_03FC, r); check("ram_top_word", r & 32'hFF00_00FF, 32'h1300_00DF);
    rd(32'h0000_0000, r); check("ram_word0", r, 32'h0BAD_F00D);

    // Console backpressure and overflow
    do_reset();
    for (int i = 0; i < 5; i++) wr(BASE + 32'h4, {24'h0, msg[i]}, 4'b0001);
    rd(BASE + 32'h4, r); check("con_stat_full", r, 32'h1);
    check("con_ovf_set", 32'(con_ovf), 32'd1);
    for (int i = 0; i < 4; i++) drain($sformatf("bp%0d", i), msg[i]);
    check("con_empty_valid", 32'(con_valid), 32'd0);
    rd(BASE + 32'h4, r); check("con_stat_empty", r, 32'h2);

    // Push into full FIFO while popping
    do_reset();
    for (int i = 0; i < 4; i++) wr(BASE + 32'h4, {24'h0, abcd[i]}, 4'b0001);
    @(negedge clk);
    MemWrite = 1'b1; DataAdr = BASE + 32'h4; WriteData = 32'h5A; ByteEn = 4'b0001;
    con_ready = 1'b1;
    @(negedge clk);
    idle(); con_ready = 1'b0;
    check("pp_no_ovf", 32'(con_ovf), 32'd0);
    rd(BASE + 32'h4, r); check("pp_still_full", r, 32'h1);
    drain("pp0", 8'h62);
    drain("pp1", 8'h63);
    drain("pp2", 8'h64);
    drain("pp3", 8'h5A);
    check("pp_empty", 32'(con_valid), 32'd0);

    // Unmapped access
    check("ue_pre", 32'(bus_err), 32'd0);
    rd(BASE + 32'hC, r); check("mmio_c_zero", r, 32'd0);
    wr(32'h4000_0000, 32'h0000_1234, 4'hF);
    check("ue_bus_err", 32'(bus_err), 32'd1);
    rd(32'h0000_0000, r); check("ue_ram_kept", r, 32'h0BAD_F00D);
    rd(32'h4000_0000, r); check("ue_read_zero", r, 32'd0);

    // Reset with queued bytes and a write in the reset cycle
    wr(BASE + 32'h4, 32'h70, 4'b0001);
    wr(BASE + 32'h4, 32'h71, 4'b0001);
    check("q_valid", 32'(con_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    MemWrite = 1'b1; DataAdr = 32'h10; WriteData = 32'h1111_1111; ByteEn = 4'hF;
    @(negedge clk);
    idle();
    @(negedge clk);
    reset = 1'b0;
    check("rr_con_valid", 32'(con_valid), 32'd0);
    check("rr_con_data",  32'(con_data),  32'd0);
    check("rr_bus_err",   32'(bus_err),   32'd0);
    rd(32'h0000_0010, r); check("rr_ram_kept", r, 32'hAABB_EEDD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
